// File: rtl/ins_fetcher_pkg.sv
// Shared constants, state encoding and immediate decoders for the instruction fetcher.
package ins_fetcher_pkg;

  localparam int unsigned ICACHE_LINES_DEF = 64;
  localparam int unsigned BHT_ENTRIES_DEF  = 256;

  localparam logic        TRUE  = 1'b1;
  localparam logic        FALSE = 1'b0;
  localparam logic [31:0] ZERO  = '0;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] BHT_INIT = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_icache.sv
// Direct-mapped one-word-per-line I-cache: combinational hit/data lookup, synchronous refill write.
module fetch_icache #(
  parameter int unsigned LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] rd_word_i,
  output logic        hit_o,
  output logic [31:0] rd_data_o,
  input  logic        we_i,
  input  logic [29:0] wr_word_i,
  input  logic [31:0] wr_data_i
);
  import ins_fetcher_pkg::*;

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_word_i[IDX_W-1:0];
  assign rd_tag = rd_word_i[29:IDX_W];
  assign wr_idx = wr_word_i[IDX_W-1:0];
  assign wr_tag = wr_word_i[29:IDX_W];

  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx] <= TRUE;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && we_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ins_fetcher.sv
// Fetch stage: PC, I-cache lookup/refill FSM, BHT-based branch/JAL prediction, dispatcher handshake.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter int unsigned ICACHE_LINES = ICACHE_LINES_DEF,
  parameter int unsigned BHT_ENTRIES  = BHT_ENTRIES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_signal,
  input  logic [31:0] rollback_pc,
  input  logic        is_full,
  output logic        valid_2dsp,
  output logic [31:0] pc_2dsp,
  output logic [31:0] instr_2dsp,
  output logic        if_jump_2dsp,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_instr,
  input  logic        bp_upd_valid,
  input  logic [31:0] bp_upd_pc,
  input  logic        bp_upd_taken
);

  localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         valid_q;
  logic [31:0]  pc_out_q;
  logic [31:0]  instr_q;
  logic         jump_q;
  logic         req_valid_q;
  logic [29:0]  req_word_q;
  logic [1:0]   bht_q [BHT_ENTRIES];

  logic        ic_hit;
  logic [31:0] ic_data;
  logic        ic_we;
  logic        advance;
  logic        pred_taken;
  logic [31:0] next_pc_d;
  logic        jump_d;
  logic [BHT_W-1:0] bht_rd_idx, bht_wr_idx;
  logic        unused_bits;

  assign unused_bits = ^bp_upd_pc;

  assign advance = !valid_q || !is_full;
  assign ic_we   = !rst && !rollback_signal && rdy && (state_q == MISS) && mem_resp_valid;

  fetch_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk      (clk),
    .rst      (rst),
    .rd_word_i(pc_q[31:2]),
    .hit_o    (ic_hit),
    .rd_data_o(ic_data),
    .we_i     (ic_we),
    .wr_word_i(req_word_q),
    .wr_data_i(mem_resp_instr)
  );

  assign bht_rd_idx = pc_q[BHT_W+1:2];
  assign bht_wr_idx = bp_upd_pc[BHT_W+1:2];
  assign pred_taken = bht_q[bht_rd_idx][1];

  always_comb begin
    next_pc_d = pc_q + 32'd4;
    jump_d    = FALSE;
    if (ic_data[6:0] == OP_JAL) begin
      next_pc_d = pc_q + imm_j(ic_data);
      jump_d    = TRUE;
    end else if (ic_data[6:0] == OP_BRANCH && pred_taken) begin
      next_pc_d = pc_q + imm_b(ic_data);
      jump_d    = TRUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= ZERO;
      valid_q     <= FALSE;
      pc_out_q    <= ZERO;
      instr_q     <= ZERO;
      jump_q      <= FALSE;
      req_valid_q <= FALSE;
      req_word_q  <= '0;
    end else if (rollback_signal) begin
      state_q     <= IDLE;
      pc_q        <= rollback_pc;
      valid_q     <= FALSE;
      req_valid_q <= FALSE;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (advance) begin
            if (ic_hit) begin
              valid_q  <= TRUE;
              pc_out_q <= pc_q;
              instr_q  <= ic_data;
              jump_q   <= jump_d;
              pc_q     <= next_pc_d;
            end else begin
              valid_q     <= FALSE;
              req_valid_q <= TRUE;
              req_word_q  <= pc_q[31:2];
              state_q     <= MISS;
            end
          end
        end
        MISS: begin
          if (mem_resp_valid) begin
            req_valid_q <= FALSE;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Commit-time training runs independently of the fetch pipeline, including across stalls and flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= BHT_INIT;
      end
    end else if (rdy && bp_upd_valid) begin
      if (bp_upd_taken) begin
        if (bht_q[bht_wr_idx] != 2'b11) bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] + 2'b01;
      end else begin
        if (bht_q[bht_wr_idx] != 2'b00) bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] - 2'b01;
      end
    end
  end

  assign valid_2dsp    = valid_q;
  assign pc_2dsp       = pc_out_q;
  assign instr_2dsp    = instr_q;
  assign if_jump_2dsp  = jump_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = {req_word_q, 2'b00};

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: cycle-vector table plus sequences for refill, prediction and flush.
module tb_ins_fetcher;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0100_006F;
  localparam logic [31:0] BEQ = 32'h0000_0463;
  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback_signal, is_full;
  logic [31:0] rollback_pc;
  logic        valid_2dsp, if_jump_2dsp, mem_req_valid;
  logic [31:0] pc_2dsp, instr_2dsp, mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_instr;
  logic        bp_upd_valid, bp_upd_taken;
  logic [31:0] bp_upd_pc;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic        mon_en  = 1'b0;
  logic        seen_100 = 1'b0;

  always #5 clk = ~clk;

  ins_fetcher dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback_signal(rollback_signal),
    .rollback_pc    (rollback_pc),
    .is_full        (is_full),
    .valid_2dsp     (valid_2dsp),
    .pc_2dsp        (pc_2dsp),
    .instr_2dsp     (instr_2dsp),
    .if_jump_2dsp   (if_jump_2dsp),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_instr (mem_resp_instr),
    .bp_upd_valid   (bp_upd_valid),
    .bp_upd_pc      (bp_upd_pc),
    .bp_upd_taken   (bp_upd_taken)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h20:  return JAL;
      32'h40:  return BEQ;
      default: return NOP;
    endcase
  endfunction

  // Memory model: answers a held request LAT cycles after first seeing it; a flush aborts it.
  initial begin
    int unsigned cnt;
    cnt = 0;
    mem_resp_valid = 1'b0;
    mem_resp_instr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req_valid && !rollback_signal && !rst) begin
        cnt++;
        if (cnt >= LAT) begin
          mem_resp_valid = 1'b1;
          mem_resp_instr = word_at(mem_req_addr);
        end
      end else begin
        cnt = 0;
        mem_resp_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && valid_2dsp && pc_2dsp == 32'h100) seen_100 = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] epc,
                            input logic [31:0] eins, input logic ej);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!valid_2dsp && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!valid_2dsp) begin
      check({nm, "_timeout"}, 32'(valid_2dsp), 32'd1);
    end else begin
      check({nm, "_pc"}, pc_2dsp, epc);
      check({nm, "_instr"}, instr_2dsp, eins);
      check({nm, "_jump"}, 32'(if_jump_2dsp), 32'(ej));
    end
  endtask

  task automatic do_rollback(input logic [31:0] target);
    rollback_signal = 1'b1;
    rollback_pc     = target;
    @(negedge clk);
    rollback_signal = 1'b0;
  endtask

  task automatic bp_update(input logic taken);
    bp_upd_valid = 1'b1;
    bp_upd_pc    = 32'h40;
    bp_upd_taken = taken;
    @(negedge clk);
    bp_upd_valid = 1'b0;
  endtask

  typedef struct {
    logic        rb;
    logic [31:0] rb_pc;
    logic        full;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_jump;
    logic [31:0] e_instr;
    logic        e_req;
  } vec_t;

  localparam int unsigned NV = 18;
  vec_t vecs [NV];

  initial begin
    int unsigned lat;
    logic [31:0] exp_pcs [11];

    vecs[0]  = '{1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, NOP, 1'b0};
    vecs[1]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, NOP, 1'b0};
    vecs[2]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, NOP, 1'b0};
    vecs[3]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h08, 1'b0, NOP, 1'b0};
    vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b0, NOP, 1'b0};
    vecs[5]  = '{1'b1, 32'h08, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, NOP, 1'b0};
    vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, 1'b0, NOP, 1'b0};
    vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, 1'b0, NOP, 1'b0};
    vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, 1'b0, NOP, 1'b0};
    vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, 1'b0, NOP, 1'b0};
    vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b0, NOP, 1'b0};
    vecs[11] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, NOP, 1'b0};
    vecs[12] = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, NOP, 1'b0};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, JAL, 1'b0};
    vecs[14] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h30, 1'b0, NOP, 1'b0};
    vecs[15] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h30, 1'b0, NOP, 1'b0};
    vecs[16] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h30, 1'b0, NOP, 1'b0};
    vecs[17] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h34, 1'b0, NOP, 1'b0};

    exp_pcs = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                32'h20, 32'h30, 32'h34, 32'h38};

    rst = 1'b1; rdy = 1'b1; rollback_signal = 1'b0; rollback_pc = '0; is_full = 1'b0;
    bp_upd_valid = 1'b0; bp_upd_pc = '0; bp_upd_taken = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_2dsp), 32'd0);
    check("rst_pc", pc_2dsp, 32'h0);
    check("rst_instr", instr_2dsp, 32'h0);
    check("rst_jump", 32'(if_jump_2dsp), 32'd0);
    check("rst_req", 32'(mem_req_valid), 32'd0);
    check("rst_addr", mem_req_addr, 32'h0);

    // Cold start: miss at 0, refill, first presentation four cycles after the request
    rst = 1'b0;
    @(negedge clk);
    check("cold_req", 32'(mem_req_valid), 32'd1);
    check("cold_addr", mem_req_addr, 32'h0);
    lat = 0;
    while (!valid_2dsp && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("cold_latency", lat, 32'd4);
    check("cold_pc", pc_2dsp, 32'h0);
    check("cold_instr", instr_2dsp, NOP);
    foreach (exp_pcs[i]) begin
      wait_valid($sformatf("stream_%0h", exp_pcs[i]), exp_pcs[i], word_at(exp_pcs[i]),
                 exp_pcs[i] == 32'h20);
    end

    // Cached hits, is_full stall, JAL redirect and rdy freeze, cycle by cycle
    for (int i = 0; i < NV; i++) begin
      rollback_signal = vecs[i].rb;
      rollback_pc     = vecs[i].rb_pc;
      is_full         = vecs[i].full;
      rdy             = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(valid_2dsp), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_req", i), 32'(mem_req_valid), 32'(vecs[i].e_req));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_pc", i), pc_2dsp, vecs[i].e_pc);
        check($sformatf("vec%0d_jump", i), 32'(if_jump_2dsp), 32'(vecs[i].e_jump));
        check($sformatf("vec%0d_instr", i), instr_2dsp, vecs[i].e_instr);
      end
    end
    rollback_signal = 1'b0; is_full = 1'b0; rdy = 1'b1;

    // Branch prediction training on BEQ +8 at 0x40
    do_rollback(32'h40);
    wait_valid("beq_cold", 32'h40, BEQ, 1'b0);
    wait_valid("beq_cold_next", 32'h44, NOP, 1'b0);
    bp_update(1'b1);
    do_rollback(32'h40);
    wait_valid("beq_t1", 32'h40, BEQ, 1'b1);
    wait_valid("beq_t1_next", 32'h48, NOP, 1'b0);
    bp_update(1'b0);
    bp_update(1'b0);
    do_rollback(32'h40);
    wait_valid("beq_n2", 32'h40, BEQ, 1'b0);
    wait_valid("beq_n2_next", 32'h44, NOP, 1'b0);
    bp_update(1'b0);
    bp_update(1'b1);
    bp_update(1'b1);
    do_rollback(32'h40);
    wait_valid("beq_sat_low", 32'h40, BEQ, 1'b1);
    bp_update(1'b1);
    bp_update(1'b1);
    bp_update(1'b0);
    bp_update(1'b0);
    do_rollback(32'h40);
    wait_valid("beq_sat_high", 32'h40, BEQ, 1'b0);

    // Flush while a refill is outstanding
    mon_en = 1'b1;
    do_rollback(32'h100);
    @(negedge clk);
    check("miss_req", 32'(mem_req_valid), 32'd1);
    check("miss_addr", mem_req_addr, 32'h100);
    rollback_signal = 1'b1;
    rollback_pc     = 32'h200;
    @(negedge clk);
    rollback_signal = 1'b0;
    check("abort_req", 32'(mem_req_valid), 32'd0);
    check("abort_valid", 32'(valid_2dsp), 32'd0);
    @(negedge clk);
    check("redir_req", 32'(mem_req_valid), 32'd1);
    check("redir_addr", mem_req_addr, 32'h200);
    wait_valid("redir", 32'h200, NOP, 1'b0);
    repeat (5) @(negedge clk);
    check("no_0x100", 32'(seen_100), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
